// File: rtl/ccff_readback_capture.sv
// Config-chain readback: deserialises ccff_tail on prog_clk rising edges into words,
// queues them in an FWFT FIFO, and tracks the captured bit count and CRC-16/CCITT-FALSE.
module ccff_readback_capture #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  expected_bits,
    input  logic              prog_clk,
    input  logic              ccff_tail,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  bit_count,
    output logic [15:0]       crc
);
    localparam int AW  = $clog2(DEPTH);
    localparam int WCW = $clog2(WORD_W);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_prog_q;
    logic [WORD_W-2:0] r_shift;
    logic [WCW-1:0]    r_wcnt;
    logic [CNT_W-1:0]  r_expected, r_bit_count;
    logic [15:0]       r_crc;
    logic              r_overflow;
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [AW:0]       r_count;

    logic              w_strobe, w_last, w_word_full, w_push, w_pop, w_full, w_wr, w_arm, w_fb;
    logic [WORD_W-1:0] w_shift_nxt, w_push_dat;
    logic [WCW-1:0]    w_pad;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [15:0]       w_crc_nxt;

    assign w_strobe    = prog_clk & ~r_prog_q & (r_state == S_CAPTURE);
    assign w_shift_nxt = {r_shift, ccff_tail};
    assign w_cnt_inc   = r_bit_count + CNT_W'(1);
    assign w_last      = w_strobe & (w_cnt_inc == r_expected);
    assign w_word_full = w_strobe & (r_wcnt == WCW'(WORD_W - 1));
    assign w_push      = w_word_full | w_last;

    // A partial final word is left-justified; a full word needs zero padding.
    assign w_pad       = WCW'(WORD_W - 1) - r_wcnt;
    assign w_push_dat  = w_shift_nxt << w_pad;

    assign w_fb        = r_crc[15] ^ ccff_tail;
    assign w_crc_nxt   = {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);

    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_pop       = rd_en & (r_count != '0);
    assign w_wr        = w_push & (~w_full | w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_arm       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_arm       = 1'b1;
                    w_state_nxt = (expected_bits != '0) ? S_CAPTURE : S_DONE;
                end
            end
            S_CAPTURE: if (w_last) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_prog_q    <= 1'b0;
            r_shift     <= '0;
            r_wcnt      <= '0;
            r_expected  <= '0;
            r_bit_count <= '0;
            r_crc       <= 16'hFFFF;
            r_overflow  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_prog_q <= prog_clk;
            if (w_arm) begin
                r_expected  <= expected_bits;
                r_bit_count <= '0;
                r_shift     <= '0;
                r_wcnt      <= '0;
                r_crc       <= 16'hFFFF;
                r_overflow  <= 1'b0;
            end else if (w_strobe) begin
                r_shift     <= w_shift_nxt[WORD_W-2:0];
                r_bit_count <= w_cnt_inc;
                r_crc       <= w_crc_nxt;
                r_wcnt      <= w_push ? '0 : r_wcnt + WCW'(1);
            end
            if (w_push & w_full & ~w_pop)
                r_overflow <= 1'b1;
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr & ~w_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (w_pop & ~w_wr)
                r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr)
            r_mem[r_wr_ptr] <= w_push_dat;
    end

    assign rd_valid  = (r_count != '0);
    assign rd_data   = rd_valid ? r_mem[r_rd_ptr] : '0;
    assign busy      = (r_state == S_CAPTURE);
    assign done      = (r_state == S_DONE);
    assign overflow  = r_overflow;
    assign bit_count = r_bit_count;
    assign crc       = r_crc;
endmodule

// File: tb/tb_ccff_readback_capture.sv
// Bench for ccff_readback_capture: directed scenarios plus randomized captures checked
// against a bit-list / word-queue reference model.
module tb_ccff_readback_capture;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst, start, prog_clk, ccff_tail, rd_en;
    logic [CW-1:0] expected_bits;
    logic [W-1:0]  rd_data;
    logic          rd_valid, busy, done, overflow;
    logic [CW-1:0] bit_count;
    logic [15:0]   crc;

    always #5 clk = ~clk;

    ccff_readback_capture #(.WORD_W(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .expected_bits(expected_bits),
        .prog_clk(prog_clk), .ccff_tail(ccff_tail), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .overflow(overflow), .bit_count(bit_count), .crc(crc)
    );

    int n_checks = 0, n_pass = 0;
    int cyc = 0, done_cnt = 0, done_cyc = -1, strobe_cyc = -1;
    bit rand_rd = 0;

    // Reference model: captured bit list, FIFO word queue, sticky drop flag
    bit           m_active = 0;
    int           m_expected = 0;
    bit           m_ovf = 0;
    bit           cap_bits[$];
    logic [W-1:0] mdl_q[$], exp_q[$], got_q[$];
    bit           push_pending = 0;
    logic [W-1:0] push_word;

    function automatic logic [15:0] model_crc();
        logic [15:0] c = 16'hFFFF;
        bit fb;
        foreach (cap_bits[i]) begin
            fb = c[15] ^ cap_bits[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic tick();
        if (rand_rd) rd_en = 1'($urandom_range(0, 1));
        if (rd_en && rd_valid) got_q.push_back(rd_data);
        if (rd_en && mdl_q.size() > 0) exp_q.push_back(mdl_q.pop_front());
        if (push_pending) begin
            if (mdl_q.size() < D) mdl_q.push_back(push_word);
            else m_ovf = 1;
            push_pending = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic send_bit(input bit b);
        int n, base;
        logic [W-1:0] w;
        prog_clk  = 1'b1;
        ccff_tail = b;
        if (m_active) begin
            cap_bits.push_back(b);
            n = cap_bits.size();
            if (n % W == 0 || n == m_expected) begin
                base = ((n - 1) / W) * W;
                w = '0;
                for (int i = base; i < n; i++) w[W-1-(i-base)] = cap_bits[i];
                push_pending = 1;
                push_word    = w;
            end
            if (n == m_expected) m_active = 0;
        end
        tick();
        strobe_cyc = cyc;
        prog_clk  = 1'b0;
        ccff_tail = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic start_cap(input int n);
        start = 1'b1;
        expected_bits = CW'(n);
        if (!m_active) begin
            m_active   = (n > 0);
            m_expected = n;
            m_ovf      = 0;
            cap_bits.delete();
        end
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rd_en = 1'b0; start = 1'b0; prog_clk = 1'b0; rand_rd = 0;
        tick();
        rst = 1'b0;
        m_active = 0; m_ovf = 0; push_pending = 0;
        cap_bits.delete();
        mdl_q.delete();
    endtask

    task automatic drain();
        rand_rd = 0;
        rd_en = 1'b1;
        repeat (D + 2) tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %h want 00", rd_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
        n_checks++; if (bit_count !== '0) $display("FAIL reset_bit_count: got %0d want 0", bit_count); else n_pass++;
        n_checks++; if (crc !== 16'hFFFF) $display("FAIL reset_crc: got %h want ffff", crc); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [W-1:0] lit [2];
        int d0;
        lit[0] = 8'hA5; lit[1] = 8'h3C;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt;
        start_cap(16);
        n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
        send_byte(8'hA5);
        send_byte(8'h3C);
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++; if (done_cyc != strobe_cyc) $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, strobe_cyc); else n_pass++;
        n_checks++; if (bit_count !== 16) $display("FAIL basic_bit_count: got %0d want 16", bit_count); else n_pass++;
        n_checks++; if (crc !== model_crc()) $display("FAIL basic_crc: got %h want %h", crc, model_crc()); else n_pass++;
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL basic_rd_valid: got %b want 1", rd_valid); else n_pass++;
        drain();
        n_checks++; if (got_q.size() != 2) $display("FAIL basic_word_count: got %0d want 2", got_q.size()); else n_pass++;
        for (int i = 0; i < 2; i++)
            if (i < got_q.size()) begin
                n_checks++; if (got_q[i] !== lit[i]) $display("FAIL basic_word%0d: got %h want %h", i, got_q[i], lit[i]); else n_pass++;
            end
    endtask

    task automatic test_partial();
        logic [11:0]  pat;
        logic [W-1:0] lit [2];
        pat = 12'b1111_0000_1010;
        lit[0] = 8'hF0; lit[1] = 8'hA0;
        got_q.delete(); exp_q.delete();
        start_cap(12);
        for (int i = 11; i >= 0; i--) send_bit(pat[i]);
        n_checks++; if (done_cyc != strobe_cyc) $display("FAIL partial_done_cycle: got %0d want %0d", done_cyc, strobe_cyc); else n_pass++;
        n_checks++; if (bit_count !== 12) $display("FAIL partial_bit_count: got %0d want 12", bit_count); else n_pass++;
        n_checks++; if (crc !== model_crc()) $display("FAIL partial_crc: got %h want %h", crc, model_crc()); else n_pass++;
        drain();
        n_checks++; if (got_q.size() != 2) $display("FAIL partial_word_count: got %0d want 2", got_q.size()); else n_pass++;
        for (int i = 0; i < 2; i++)
            if (i < got_q.size()) begin
                n_checks++; if (got_q[i] !== lit[i]) $display("FAIL partial_word%0d: got %h want %h", i, got_q[i], lit[i]); else n_pass++;
            end
    endtask

    task automatic test_crc_stream();
        logic [71:0] msg;
        int d0;
        msg = "123456789";
        got_q.delete(); exp_q.delete();
        d0 = done_cnt;
        rd_en = 1'b1;
        start_cap(72);
        for (int k = 0; k < 9; k++) send_byte(msg[71-8*k -: 8]);
        drain();
        n_checks++; if (crc !== 16'h29B1) $display("FAIL crc_check_value: got %h want 29b1", crc); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL crc_overflow: got %b want 0", overflow); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL crc_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++; if (got_q.size() != 9) $display("FAIL crc_word_count: got %0d want 9", got_q.size()); else n_pass++;
        for (int k = 0; k < 9; k++)
            if (k < got_q.size()) begin
                n_checks++; if (got_q[k] !== msg[71-8*k -: 8]) $display("FAIL crc_word%0d: got %h want %h", k, got_q[k], msg[71-8*k -: 8]); else n_pass++;
            end
    endtask

    task automatic test_overflow();
        logic [7:0] b [6];
        foreach (b[i]) b[i] = 8'($urandom);
        got_q.delete(); exp_q.delete();
        rd_en = 1'b0;
        start_cap(48);
        for (int i = 0; i < 6; i++) send_byte(b[i]);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL ovf_rd_valid: got %b want 1", rd_valid); else n_pass++;
        drain();
        n_checks++; if (got_q.size() != 4) $display("FAIL ovf_word_count: got %0d want 4", got_q.size()); else n_pass++;
        for (int i = 0; i < 4; i++)
            if (i < got_q.size()) begin
                n_checks++; if (got_q[i] !== b[i]) $display("FAIL ovf_word%0d: got %h want %h", i, got_q[i], b[i]); else n_pass++;
            end
        // Fifth word lands on a full FIFO in the same cycle as a pop
        got_q.delete(); exp_q.delete();
        foreach (b[i]) b[i] = 8'($urandom);
        start_cap(40);
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_cleared_by_start: got %b want 0", overflow); else n_pass++;
        for (int i = 0; i < 4; i++) send_byte(b[i]);
        for (int i = 7; i >= 1; i--) send_bit(b[4][i]);
        rd_en = 1'b1;
        send_bit(b[4][0]);
        drain();
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_push_pop_full: got %b want 0", overflow); else n_pass++;
        n_checks++; if (got_q.size() != 5) $display("FAIL ovf_pp_word_count: got %0d want 5", got_q.size()); else n_pass++;
        for (int i = 0; i < 5; i++)
            if (i < got_q.size()) begin
                n_checks++; if (got_q[i] !== b[i]) $display("FAIL ovf_pp_word%0d: got %h want %h", i, got_q[i], b[i]); else n_pass++;
            end
    endtask

    task automatic test_ignored();
        int d0;
        do_reset();
        repeat (5) send_bit(1'($urandom));
        n_checks++; if (bit_count !== '0) $display("FAIL ign_idle_bit_count: got %0d want 0", bit_count); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL ign_idle_rd_valid: got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (crc !== 16'hFFFF) $display("FAIL ign_idle_crc: got %h want ffff", crc); else n_pass++;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt;
        start_cap(16);
        repeat (5) send_bit(1'($urandom));
        start_cap(3);
        n_checks++; if (busy !== 1'b1) $display("FAIL ign_restart_busy: got %b want 1", busy); else n_pass++;
        repeat (11) send_bit(1'($urandom));
        n_checks++; if (bit_count !== 16) $display("FAIL ign_restart_bit_count: got %0d want 16", bit_count); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL ign_restart_done: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++; if (crc !== model_crc()) $display("FAIL ign_restart_crc: got %h want %h", crc, model_crc()); else n_pass++;
        drain();
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL ign_restart_words: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) begin
                n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL ign_restart_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
            end
        d0 = done_cnt;
        start_cap(0);
        n_checks++; if (done_cyc != cyc || done_cnt - d0 != 1) $display("FAIL ign_zero_done: got cycle %0d want %0d", done_cyc, cyc); else n_pass++;
        n_checks++; if (bit_count !== '0) $display("FAIL ign_zero_bit_count: got %0d want 0", bit_count); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL ign_zero_done_width: got %b want 0", done); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL ign_zero_rd_valid: got %b want 0", rd_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        start_cap(16);
        repeat (5) send_bit(1'($urandom));
        do_reset();
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (crc !== 16'hFFFF) $display("FAIL rstmid_crc: got %h want ffff", crc); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL rstmid_rd_valid: got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (bit_count !== '0) $display("FAIL rstmid_bit_count: got %0d want 0", bit_count); else n_pass++;
        repeat (4) tick();
        n_checks++; if (done_cnt != d0) $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - d0); else n_pass++;
        test_basic();
    endtask

    task automatic test_random();
        int n, d0;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 40);
            got_q.delete(); exp_q.delete();
            d0 = done_cnt;
            start_cap(n);
            rand_rd = 1;
            for (int k = 0; k < n; k++) send_bit(1'($urandom));
            drain();
            n_checks++; if (done_cnt - d0 != 1) $display("FAIL rand%0d_done: got %0d want 1", it, done_cnt - d0); else n_pass++;
            n_checks++; if (bit_count !== CW'(n)) $display("FAIL rand%0d_bit_count: got %0d want %0d", it, bit_count, n); else n_pass++;
            n_checks++; if (crc !== model_crc()) $display("FAIL rand%0d_crc: got %h want %h", it, crc, model_crc()); else n_pass++;
            n_checks++; if (overflow !== m_ovf) $display("FAIL rand%0d_overflow: got %b want %b", it, overflow, m_ovf); else n_pass++;
            n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL rand%0d_words: got %0d want %0d", it, got_q.size(), exp_q.size()); else n_pass++;
            for (int i = 0; i < exp_q.size(); i++)
                if (i < got_q.size()) begin
                    n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rand%0d_word%0d: got %h want %h", it, i, got_q[i], exp_q[i]); else n_pass++;
                end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; expected_bits = '0;
        prog_clk = 1'b0; ccff_tail = 1'b0; rd_en = 1'b0;
        test_reset();
        test_basic();
        test_partial();
        test_crc_stream();
        test_overflow();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
